// File: rtl/mdu_sequencer_if.sv
// Request and result bundle between the EX stage and the multiply/divide sequencer.
// The EX stage drives through the master modport and the sequencer uses the slave modport.
interface mdu_sequencer_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             rd_req;
  logic             flush;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, src_a, src_b, rd_req, flush,
                  input  busy, done, stall, hi, lo);
  modport slave  (input  start, op, src_a, src_b, rd_req, flush,
                  output busy, done, stall, hi, lo);
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide unit that owns HI/LO. It uses a shift-add multiplier and a restoring divider.
// Signed operations run on magnitudes, and the signs are applied in the FIXUP state.
module mdu_sequencer #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  mdu_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_e;
  localparam int CW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [1:0]         op_q, op_d;
  logic               signA_q, signA_d, signB_q, signB_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic               reqSigned;
  logic [WIDTH-1:0]   absA, absB;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH+1:0]   trial, diff;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quoFix, remFix;

  assign reqSigned = ~bus.op[0];
  assign absA      = (reqSigned && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
  assign absB      = (reqSigned && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;

  // Multiply: the multiplier sits in the low half of acc and shifts out LSB-first.
  assign mulSum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};

  // Divide: rem_q is the partial remainder, and acc_q low half shifts dividend bits out and quotient bits in.
  assign trial = {rem_q, acc_q[WIDTH-1]};
  assign diff  = trial - {2'b00, opnd_q};

  assign prodFix = (~op_q[0] && (signA_q ^ signB_q)) ? -acc_q : acc_q;
  assign quoFix  = (~op_q[0] && (signA_q ^ signB_q)) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign remFix  = (~op_q[0] && signA_q) ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    signA_d = signA_q;
    signB_d = signB_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          op_d    = bus.op;
          signA_d = reqSigned & bus.src_a[WIDTH-1];
          signB_d = reqSigned & bus.src_b[WIDTH-1];
          count_d = '0;
          rem_d   = '0;
          if (bus.op[1]) begin
            opnd_d = absB;
            acc_d  = {{WIDTH{1'b0}}, absA};
            if (bus.src_b == '0) begin
              hi_d    = bus.src_a;
              lo_d    = '1;
              state_d = DONE;
            end else begin
              state_d = CALC;
            end
          end else begin
            opnd_d  = absA;
            acc_d   = {{WIDTH{1'b0}}, absB};
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          count_d = count_q + 1'b1;
          if (op_q[1]) begin
            rem_d = diff[WIDTH+1] ? trial[WIDTH:0] : diff[WIDTH:0];
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~diff[WIDTH+1]};
          end else begin
            acc_d = {mulSum, acc_q[WIDTH-1:1]};
          end
          if (count_q == CW'(WIDTH-1)) state_d = FIXUP;
        end
      end
      FIXUP: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          if (op_q[1]) begin
            hi_d = remFix;
            lo_d = quoFix;
          end else begin
            {hi_d, lo_d} = prodFix;
          end
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      op_q    <= '0;
      signA_q <= 1'b0;
      signB_q <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      signA_q <= signA_d;
      signB_q <= signB_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // HI/LO are already valid in DONE, so only the CALC/FIXUP states hold the pipeline.
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == DONE);
  assign bus.stall = ((state_q == CALC) || (state_q == FIXUP)) && (bus.start || bus.rd_req);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer with directed vectors, randomized ops against a reference model,
// and handshake corner cases.
module tb_mdu_sequencer;
  localparam int W     = 32;
  localparam int LIMIT = 200;
  localparam int LAT   = W + 1;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] expHi;
    logic [W-1:0] expLo;
    int           expLat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  mdu_sequencer_if #(.WIDTH(W)) bus ();
  mdu_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference results from plain 64-bit arithmetic, with truncating signed division.
  function automatic void refModel(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint      sa, sb, q, r;
    logic [63:0] p, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    hi = '0;
    lo = '0;
    case (op)
      2'd0: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      2'd1: begin p = ua * ub; hi = p[63:32]; lo = p[31:0]; end
      default: begin
        if (b == '0) begin
          hi = a;
          lo = '1;
        end else if (op == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
          hi = 32'(r);
          lo = 32'(q);
        end else begin
          hi = a % b;
          lo = a / b;
        end
      end
    endcase
  endfunction

  task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               output int lat);
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic runOp(input string name, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] expHi, input logic [W-1:0] expLo, input int expLat);
    int lat;
    applyStimulus(op, a, b, lat);
    checkOutput({name, " latency"}, 64'(lat), 64'(expLat));
    checkOutput({name, " hi"}, 64'(bus.hi), 64'(expHi));
    checkOutput({name, " lo"}, 64'(bus.lo), 64'(expLo));
    @(negedge clk);
    checkOutput({name, " busy after"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    vec_t         vecs[7];
    logic [1:0]   rop;
    logic [W-1:0] ra, rb, eh, el;
    int           lat, doneSeen;

    vecs[0] = '{2'd1, 32'd7,          32'd6,          32'h0,          32'd42,         LAT};
    vecs[1] = '{2'd0, 32'hFFFFFFFD,   32'd5,          32'hFFFFFFFF,   32'hFFFFFFF1,   LAT};
    vecs[2] = '{2'd2, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   32'hFFFFFFFD,   LAT};
    vecs[3] = '{2'd3, 32'd100,        32'd7,          32'd2,          32'd14,         LAT};
    vecs[4] = '{2'd3, 32'h10,         32'h0,          32'h10,         32'hFFFFFFFF,   0};
    vecs[5] = '{2'd2, 32'h80000000,   32'hFFFFFFFF,   32'h0,          32'h80000000,   LAT};
    vecs[6] = '{2'd0, 32'h80000000,   32'h80000000,   32'h40000000,   32'h0,          LAT};

    bus.start  = 1'b0;
    bus.op     = 2'd0;
    bus.src_a  = '0;
    bus.src_b  = '0;
    bus.rd_req = 1'b0;
    bus.flush  = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("reset busy", 64'(bus.busy), 64'd0);
    checkOutput("reset done", 64'(bus.done), 64'd0);
    checkOutput("reset stall", 64'(bus.stall), 64'd0);
    checkOutput("reset hi", 64'(bus.hi), 64'd0);
    checkOutput("reset lo", 64'(bus.lo), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expHi, vecs[i].expLo, vecs[i].expLat);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 20);
      if ($urandom_range(0, 7) == 0) rb = '0;
      refModel(rop, ra, rb, eh, el);
      runOp($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, eh, el, (rop[1] && rb == '0) ? 0 : LAT);
    end

    // Flush at CALC count 10 aborts the op and keeps the previous result.
    runOp("pre-flush", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, LAT);
    bus.op = 2'd0; bus.src_a = 32'hFFFFFFFD; bus.src_b = 32'd5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checkOutput("flush busy", 64'(bus.busy), 64'd0);
    doneSeen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) doneSeen++;
    end
    checkOutput("flush no done", 64'(doneSeen), 64'd0);
    checkOutput("flush hi kept", 64'(bus.hi), 64'd2);
    checkOutput("flush lo kept", 64'(bus.lo), 64'd14);

    // Flush together with start in IDLE means nothing is accepted.
    bus.op = 2'd3; bus.src_a = 32'd5; bus.src_b = 32'd0; bus.start = 1'b1; bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    checkOutput("idle flush busy", 64'(bus.busy), 64'd0);
    checkOutput("idle flush done", 64'(bus.done), 64'd0);
    checkOutput("idle flush hi", 64'(bus.hi), 64'd2);

    // rd_req held during a mult stalls every busy cycle except DONE.
    bus.op = 2'd1; bus.src_a = 32'd3; bus.src_b = 32'd4; bus.start = 1'b1; bus.rd_req = 1'b1;
    checkOutput("rdreq stall idle", 64'(bus.stall), 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k <= LAT + 1; k++) begin
      checkOutput($sformatf("rdreq stall c%0d", k), 64'(bus.stall), (k < LAT) ? 64'd1 : 64'd0);
      if (k == LAT) checkOutput("rdreq done", 64'(bus.done), 64'd1);
      if (k <= LAT) @(negedge clk);
    end
    bus.rd_req = 1'b0;
    checkOutput("rdreq lo", 64'(bus.lo), 64'd12);

    // start held during a mult is ignored until IDLE, and then the second op is accepted.
    bus.op = 2'd1; bus.src_a = 32'd7; bus.src_b = 32'd6; bus.start = 1'b1;
    @(negedge clk);
    bus.src_a = 32'h12345678; bus.src_b = 32'h10;
    for (int k = 0; k <= LAT + 1; k++) begin
      checkOutput($sformatf("hold stall c%0d", k), 64'(bus.stall), (k < LAT) ? 64'd1 : 64'd0);
      if (k == LAT) checkOutput("hold first lo", 64'(bus.lo), 64'd42);
      if (k == LAT + 1) checkOutput("hold idle busy", 64'(bus.busy), 64'd0);
      if (k <= LAT) @(negedge clk);
    end
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("hold second latency", 64'(lat), 64'(LAT));
    checkOutput("hold second hi", 64'(bus.hi), 64'h1);
    checkOutput("hold second lo", 64'(bus.lo), 64'h23456780);

    // An asynchronous reset mid-CALC clears everything immediately.
    @(negedge clk);
    bus.op = 2'd1; bus.src_a = 32'd7; bus.src_b = 32'd6; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.rd_req = 1'b1;
    #1;
    checkOutput("pre-reset stall", 64'(bus.stall), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midreset busy", 64'(bus.busy), 64'd0);
    checkOutput("midreset done", 64'(bus.done), 64'd0);
    checkOutput("midreset stall", 64'(bus.stall), 64'd0);
    checkOutput("midreset hi", 64'(bus.hi), 64'd0);
    checkOutput("midreset lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.rd_req = 1'b0;
    @(negedge clk);
    runOp("post-reset", 2'd1, 32'd7, 32'd6, 32'd0, 32'd42, LAT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
